// File: rtl/score_request_initiator.sv
// Game-side initiator of the score-increment handshake: catches prize-sensor rises,
// queues them, and issues one four-phase request per queued prize with a timeout.
module score_request_initiator #(
  parameter int CNT_W          = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TO_W           = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             prize_sensor,
  input  logic             finished_incrementing_score,
  input  logic [31:0]      score,
  output logic             need_to_increment_score,
  output logic [CNT_W-1:0] pending_count,
  output logic [15:0]      prizes_credited,
  output logic [31:0]      last_score,
  output logic             busy,
  output logic             overflow,
  output logic             timeout_error
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_ACK   = 2'd2,
    ST_ERROR = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(TIMEOUT_CYCLES - 1);

  state_t             state_q, state_d;
  logic [2:0]         sync_q, sync_d;
  logic [TO_W-1:0]    timer_q, timer_d;
  logic [CNT_W-1:0]   pending_q, pending_d;
  logic               overflow_q, overflow_d;
  logic [15:0]        credited_q, credited_d;
  logic [31:0]        last_score_q, last_score_d;

  logic               prize_event;
  logic               ack_accept;
  logic               timer_hit;
  logic [TO_W-1:0]    timer_step;

  // sync_q[0] and sync_q[1] form the synchroniser; sync_q[2] is the edge-detect delay
  assign sync_d      = {sync_q[1:0], prize_sensor};
  assign prize_event = sync_q[1] & ~sync_q[2];
  assign ack_accept  = (state_q == ST_REQ) && finished_incrementing_score;

  always_comb begin
    pending_d    = pending_q;
    overflow_d   = overflow_q;
    credited_d   = credited_q;
    last_score_d = last_score_q;
    if (prize_event && !ack_accept) begin
      if (pending_q == CNT_MAX) begin
        overflow_d = 1'b1;
      end else begin
        pending_d = pending_q + CNT_W'(1);
      end
    end else if (ack_accept && !prize_event) begin
      pending_d = pending_q - CNT_W'(1);
    end
    if (ack_accept) begin
      credited_d   = credited_q + 16'd1;
      last_score_d = score;
    end
  end

  // Timer saturates at the limit so a late ack never lets it wrap back into range
  assign timer_hit  = (timer_q == TO_LIMIT);
  assign timer_step = timer_hit ? timer_q : timer_q + TO_W'(1);

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    case (state_q)
      ST_IDLE: begin
        if ((pending_q != '0) && !finished_incrementing_score) begin
          state_d = ST_REQ;
          timer_d = '0;
        end
      end
      ST_REQ: begin
        timer_d = timer_step;
        if (finished_incrementing_score) begin
          state_d = ST_ACK;
        end else if (timer_hit) begin
          state_d = ST_ERROR;
        end
      end
      ST_ACK: begin
        timer_d = timer_step;
        if (!finished_incrementing_score) begin
          state_d = ST_IDLE;
        end else if (timer_hit) begin
          state_d = ST_ERROR;
        end
      end
      ST_ERROR: begin
        state_d = ST_ERROR;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      sync_q       <= '0;
      timer_q      <= '0;
      pending_q    <= '0;
      overflow_q   <= 1'b0;
      credited_q   <= '0;
      last_score_q <= '0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      timer_q      <= timer_d;
      pending_q    <= pending_d;
      overflow_q   <= overflow_d;
      credited_q   <= credited_d;
      last_score_q <= last_score_d;
    end
  end

  assign need_to_increment_score = (state_q == ST_REQ);
  assign busy                    = (state_q != ST_IDLE);
  assign timeout_error           = (state_q == ST_ERROR);
  assign pending_count           = pending_q;
  assign overflow                = overflow_q;
  assign prizes_credited         = credited_q;
  assign last_score              = last_score_q;

endmodule

// File: tb/tb_score_request_initiator.sv
// Bench for score_request_initiator: a table-driven single-prize run, directed corner
// sequences, then randomized traffic checked against a prize/handshake reference model.
module tb_score_request_initiator;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        prize_sensor = 1'b0;
  logic        ack = 1'b0;
  logic [31:0] score = 32'd0;

  logic        need_b, busy_b, ovf_b, to_b;
  logic [3:0]  pend_b;
  logic [15:0] cred_b;
  logic [31:0] last_b;
  logic        need_s, busy_s, ovf_s, to_s;
  logic [1:0]  pend_s;
  logic [15:0] cred_s;
  logic [31:0] last_s;

  score_request_initiator #(.CNT_W(4), .TIMEOUT_CYCLES(64), .TO_W(8)) u_big (
    .clock(clock), .reset(reset), .prize_sensor(prize_sensor),
    .finished_incrementing_score(ack), .score(score),
    .need_to_increment_score(need_b), .pending_count(pend_b),
    .prizes_credited(cred_b), .last_score(last_b), .busy(busy_b),
    .overflow(ovf_b), .timeout_error(to_b));

  score_request_initiator #(.CNT_W(2), .TIMEOUT_CYCLES(16), .TO_W(8)) u_small (
    .clock(clock), .reset(reset), .prize_sensor(prize_sensor),
    .finished_incrementing_score(ack), .score(score),
    .need_to_increment_score(need_s), .pending_count(pend_s),
    .prizes_credited(cred_s), .last_score(last_s), .busy(busy_s),
    .overflow(ovf_s), .timeout_error(to_s));

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: prizes are counted from the sensor history, requests are
  // tracked as a handshake phase plus elapsed cycles since the request began.
  localparam int P_IDLE = 0, P_REQ = 1, P_ACK = 2, P_ERR = 3;
  int          m_pend[2], m_ph[2], m_el[2], m_cred[2], m_ovf[2];
  logic [31:0] m_last[2];
  int          m_max[2] = '{15, 3};
  int          m_tmo[2] = '{64, 16};
  int          hist[3];

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_pend[i] = 0; m_ph[i] = P_IDLE; m_el[i] = 0; m_cred[i] = 0; m_ovf[i] = 0; m_last[i] = '0;
    end
    for (int k = 0; k < 3; k++) hist[k] = 0;
  endfunction

  function automatic void model_edge();
    bit ev;
    ev = (hist[1] == 1) && (hist[2] == 0);
    for (int i = 0; i < 2; i++) begin
      bit take;
      int old;
      take = (m_ph[i] == P_REQ) && ack;
      old  = m_pend[i];
      if (ev && !take) begin
        if (m_pend[i] == m_max[i]) m_ovf[i] = 1;
        else m_pend[i]++;
      end else if (take && !ev) begin
        m_pend[i]--;
      end
      if (take) begin
        m_cred[i] = (m_cred[i] + 1) % 65536;
        m_last[i] = score;
      end
      case (m_ph[i])
        P_IDLE: if (old != 0 && !ack) begin m_ph[i] = P_REQ; m_el[i] = 0; end
        P_REQ: begin
          if (ack) m_ph[i] = P_ACK;
          else if (m_el[i] >= m_tmo[i] - 1) m_ph[i] = P_ERR;
          m_el[i]++;
        end
        P_ACK: begin
          if (!ack) m_ph[i] = P_IDLE;
          else if (m_el[i] >= m_tmo[i] - 1) m_ph[i] = P_ERR;
          m_el[i]++;
        end
        default: ;
      endcase
    end
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = int'(prize_sensor);
  endfunction

  task automatic step();
    @(posedge clock);
    if (!reset) model_reset();
    else model_edge();
    #1;
  endtask

  task automatic do_reset();
    prize_sensor = 1'b0;
    ack = 1'b0;
    reset = 1'b0;
    model_reset();
    step();
    step();
    reset = 1'b1;
  endtask

  function automatic logic [63:0] outs(input int i);
    if (i == 0) return {8'd0, need_b, busy_b, to_b, ovf_b, pend_b, cred_b, last_b};
    return {8'd0, need_s, busy_s, to_s, ovf_s, 2'b00, pend_s, cred_s, last_s};
  endfunction

  function automatic logic [63:0] model_outs(input int i);
    return {8'd0, m_ph[i] == P_REQ, m_ph[i] != P_IDLE, m_ph[i] == P_ERR, m_ovf[i] != 0,
            4'(m_pend[i]), 16'(m_cred[i]), m_last[i]};
  endfunction

  function automatic logic get_need(input int i);
    return (i == 0) ? need_b : need_s;
  endfunction

  function automatic logic get_busy(input int i);
    return (i == 0) ? busy_b : busy_s;
  endfunction

  task automatic handshake(input int i, input string nm);
    int n = 0;
    while (get_need(i) == 1'b0 && n < 200) begin
      step();
      n++;
    end
    chk({nm, "_need_seen"}, 64'(get_need(i)), 64'd1);
    ack = 1'b1;
    step();
    ack = 1'b0;
    step();
    chk({nm, "_idle_gap"}, 64'(get_busy(i)), 64'd0);
    $display("handshake %s done after %0d wait cycles", nm, n);
  endtask

  task automatic pulse(input int hi, input int lo);
    prize_sensor = 1'b1;
    repeat (hi) step();
    prize_sensor = 1'b0;
    repeat (lo) step();
  endtask

  typedef struct {
    logic        s;
    logic        a;
    logic [31:0] sc;
    logic        need;
    logic        busy;
    logic [3:0]  pend;
    logic [15:0] cred;
    logic [31:0] last;
  } vec_t;

  initial begin
    vec_t tbl[10];
    logic [31:0] sa, sb, sc;
    int cnt;
    sa = 32'h0000_1111; sb = 32'h1234_5678; sc = 32'h0BAD_F00D;
    //          s     a     score need  busy  pend  cred   last
    tbl[0] = '{1'b1, 1'b0, sa, 1'b0, 1'b0, 4'd0, 16'd0, 32'd0};
    tbl[1] = '{1'b1, 1'b0, sa, 1'b0, 1'b0, 4'd0, 16'd0, 32'd0};
    tbl[2] = '{1'b1, 1'b0, sa, 1'b0, 1'b0, 4'd1, 16'd0, 32'd0};
    tbl[3] = '{1'b1, 1'b0, sa, 1'b1, 1'b1, 4'd1, 16'd0, 32'd0};
    tbl[4] = '{1'b1, 1'b0, sa, 1'b1, 1'b1, 4'd1, 16'd0, 32'd0};
    tbl[5] = '{1'b0, 1'b0, sa, 1'b1, 1'b1, 4'd1, 16'd0, 32'd0};
    tbl[6] = '{1'b0, 1'b1, sb, 1'b0, 1'b1, 4'd0, 16'd1, sb};
    tbl[7] = '{1'b0, 1'b1, sc, 1'b0, 1'b1, 4'd0, 16'd1, sb};
    tbl[8] = '{1'b0, 1'b0, sc, 1'b0, 1'b0, 4'd0, 16'd1, sb};
    tbl[9] = '{1'b0, 1'b0, sc, 1'b0, 1'b0, 4'd0, 16'd1, sb};

    model_reset();
    #1;
    chk("reset_state_big", outs(0), 64'd0);
    chk("reset_state_small", outs(1), 64'd0);
    step();
    step();
    reset = 1'b1;

    // Single prize, table-driven on the wide instance
    for (int i = 0; i < 10; i++) begin
      prize_sensor = tbl[i].s;
      ack = tbl[i].a;
      score = tbl[i].sc;
      step();
      chk($sformatf("single_vec%0d", i), outs(0),
          {8'd0, tbl[i].need, tbl[i].busy, 1'b0, 1'b0, tbl[i].pend, tbl[i].cred, tbl[i].last});
      $display("single vec %0d applied: need=%0b pend=%0d cred=%0d", i, need_b, pend_b, cred_b);
    end

    // Burst of three pulses with a stalled responder
    do_reset();
    for (int p = 0; p < 3; p++) pulse(4, 4);
    chk("burst_pending", 64'(pend_b), 64'd3);
    chk("burst_need_held", 64'(need_b), 64'd1);
    for (int k = 0; k < 3; k++) handshake(0, $sformatf("burst%0d", k));
    repeat (5) step();
    chk("burst_credited", 64'(cred_b), 64'd3);
    chk("burst_pending_end", 64'(pend_b), 64'd0);
    chk("burst_no_extra_req", 64'(need_b), 64'd0);
    chk("burst_overflow", 64'(ovf_b), 64'd0);

    // Saturation on the narrow instance
    do_reset();
    for (int p = 0; p < 5; p++) pulse(1, 1);
    repeat (3) step();
    chk("sat_pending", 64'(pend_s), 64'd3);
    chk("sat_overflow", 64'(ovf_s), 64'd1);
    for (int k = 0; k < 3; k++) handshake(1, $sformatf("sat%0d", k));
    repeat (3) step();
    chk("sat_credited", 64'(cred_s), 64'd3);
    chk("sat_drained", 64'(pend_s), 64'd0);
    chk("sat_overflow_sticky", 64'(ovf_s), 64'd1);

    // Event coincides with ack accept while pending is 2
    do_reset();
    pulse(1, 1);
    pulse(1, 2);
    chk("simul_setup_pend", 64'(pend_b), 64'd2);
    pulse(1, 1);
    chk("simul_pre_pend", 64'(pend_b), 64'd2);
    ack = 1'b1;
    step();
    chk("simul_pend", 64'(pend_b), 64'd2);
    chk("simul_credited", 64'(cred_b), 64'd1);
    ack = 1'b0;
    step();

    // Timeout with no responder
    do_reset();
    pulse(1, 1);
    cnt = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (need_s) cnt++;
    end
    chk("to_need_cycles", 64'(cnt), 64'd16);
    chk("to_error", 64'(to_s), 64'd1);
    chk("to_need_low", 64'(need_s), 64'd0);
    chk("to_busy", 64'(busy_s), 64'd1);
    pulse(1, 3);
    chk("to_pending_still_counts", 64'(pend_s), 64'd2);

    // Stale ack blocks a new request
    do_reset();
    ack = 1'b1;
    pulse(1, 9);
    chk("stale_pending", 64'(pend_s), 64'd1);
    chk("stale_no_req", 64'(need_s), 64'd0);
    ack = 1'b0;
    step();
    chk("stale_req_after_drop", 64'(need_s), 64'd1);

    // Reset in the middle of a request
    do_reset();
    pulse(1, 1);
    pulse(1, 2);
    chk("rst_setup_pend", 64'(pend_s), 64'd2);
    chk("rst_setup_need", 64'(need_s), 64'd1);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    chk("rst_async_outputs", outs(1), 64'd0);
    step();
    step();
    reset = 1'b1;
    repeat (6) step();
    chk("rst_stays_idle", outs(1), 64'd0);

    // Randomized traffic against the reference model
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) do_reset();
      if ($urandom_range(0, 3) == 0) prize_sensor = ~prize_sensor;
      if (need_s) begin
        if ($urandom_range(0, 5) == 0) ack = 1'b1;
      end else if (ack) begin
        if ($urandom_range(0, 2) == 0) ack = 1'b0;
      end else if ($urandom_range(0, 39) == 0) begin
        ack = 1'b1;
      end
      score = $urandom;
      step();
      chk($sformatf("rand_big_c%0d", c), outs(0), model_outs(0));
      chk($sformatf("rand_small_c%0d", c), outs(1), model_outs(1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/score_request_initiator.md
Name: score_request_initiator

Overview:
- Game-side initiator of the score-increment handshake whose responder is the processor (need_to_increment_score / finished_incrementing_score).
- Synchronises and edge-detects the asynchronous prize sensor and queues caught-prize events in a saturating counter.
- Issues one four-phase request per queued event, with a per-handshake timeout, and reports credited-prize count and error status.

Parameters:
CNT_W, 4, width of pending-event counter (max queued = 2^CNT_W-1)
TIMEOUT_CYCLES, 1024, cycles allowed per handshake (REQ plus ACK combined) before error
TO_W, 16, width of timeout counter; TIMEOUT_CYCLES <= 2^TO_W

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset)
prize_sensor  input  1  asynchronous level from claw/prize chute; rising edge = one prize
finished_incrementing_score  input  1  ack from processor
score  input  32  current score from processor
need_to_increment_score  output  1  request to processor, registered
pending_count  output  CNT_W  queued, not-yet-credited events
prizes_credited  output  16  completed handshakes, wraps at 65535->0
last_score  output  32  score sampled at ack
busy  output  1  FSM not IDLE
overflow  output  1  sticky: event dropped at saturation
timeout_error  output  1  sticky: handshake timed out

Behaviour:
- Reset (reset=0): async clear of every register; all outputs 0; FSM = IDLE; need_to_increment_score drops immediately.
- Sensor path: 2-flop synchroniser s1->s2, plus delay flop s3; event = s2 & ~s3. A sensor rise meeting setup before edge E0 gives pending_count+1 at edge E0+2. Holding high produces one event; re-arms only after seen low.
- Pending counter, per edge: +1 on event, -1 on ack-accept, net 0 when both occur. At max (all ones) an event without a simultaneous decrement is dropped and overflow set.
- FSM states IDLE, REQ, ACK, ERROR; need_to_increment_score = (state==REQ) from state register.
- IDLE -> REQ: pending_count != 0 and finished_incrementing_score == 0. A stale high ack blocks a new request. need rises the cycle after the transition edge.
- REQ -> ACK: finished_incrementing_score == 1. Same edge: pending_count-1, prizes_credited+1, last_score <= score. need drops the next cycle.
- ACK -> IDLE: finished_incrementing_score == 0.
- Latency: back-to-back requests are at least one IDLE cycle apart.
- Timeout: timer clears on IDLE->REQ and counts each cycle in REQ and ACK. If it reaches TIMEOUT_CYCLES-1 with the exit condition still false, go to ERROR.
- ERROR: need=0, timeout_error=1, busy=1; pending still accepts events; exits only via reset.
- An exit condition true on the same edge the timer hits its limit takes the normal transition; no error.
- busy=1 in REQ, ACK and ERROR.
- Reset mid-handshake: request withdrawn, pending events lost, counters cleared.

Test Plan:
- Single prize: sensor 0->1 held 5 cycles; responder acks 3 cycles after need, drops ack 2 cycles later -> pending 0->1->0, need high exactly until ack seen, prizes_credited=1, last_score = score at ack edge, busy back to 0.
- Burst: 3 sensor pulses (each 4 high/4 low) while responder stalls 20 cycles -> pending reaches 3, then exactly 3 request/ack cycles with an IDLE gap between each; prizes_credited=3, overflow=0.
- Saturation: CNT_W=2, 5 pulses, no ack -> pending stops at 3, overflow=1; then acking drains to 0 and prizes_credited=3.
- Simultaneous: event edge coincides with ack accept while pending=2 -> pending stays 2, prizes_credited+1.
- Timeout/stale ack: TIMEOUT_CYCLES=16, no ack -> after 16 cycles in REQ need=0, timeout_error=1. Separately, ack held high while pending=1 -> no request until ack low.
- Reset mid-REQ: pull reset low during REQ with pending=2 -> need falls without a clock edge, all outputs 0. After release with sensor low, FSM stays IDLE.
